imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter: BR_SHIFT, default 2, left-shift applied to extended branch offsets (word-to-byte).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: instr_in  input  32  instruction word from IF/ID register.
REQ-005 Port: instr_valid  input  1  instr_in holds a real instruction (0 = bubble).
REQ-006 Port: stall  input  1  hazard unit hold; stage register keeps its contents.
REQ-007 Port: flush  input  1  squash; stage register loads a bubble.
REQ-008 Port: imm_out  output  64  registered, extended (and shifted) immediate for EX.
REQ-009 Port: imm_sel  output  3  registered immediate class: 0 NONE, 1 DADDR9, 2 IMM12, 3 BR26, 4 COND19, 5 SHAMT.
REQ-010 Port: imm_valid  output  1  registered copy of instr_valid for the held instruction.
REQ-011 Port: illegal  output  1  registered flag: valid instruction with no recognised opcode.

Function
REQ-012 Decode SHALL match, in this priority: LDUR 11111000010 / STUR 11111000000 on [31:21] -> DADDR9; LSL 11010011011 / LSR 11010011010 on [31:21] -> SHAMT; ADDI 1001000100 / SUBI 1101000100 on [31:22] -> IMM12; CBZ 10110100 / CBNZ 10110101 / B.cond 01010100 on [31:24] -> COND19; B 000101 / BL 100101 on [31:26] -> BR26; otherwise NONE.
REQ-013 DADDR9: field [20:12], sign-extended to 64 bits, no shift.
REQ-014 IMM12: field [21:10], zero-extended to 64 bits.
REQ-015 SHAMT: field [15:10], zero-extended to 64 bits.
REQ-016 COND19: field [23:5], sign-extended to 64 bits, then shifted left BR_SHIFT within 64 bits; bits shifted past bit 63 discarded.
REQ-017 BR26: field [25:0], sign-extended to 64 bits, then shifted left BR_SHIFT within 64 bits.
REQ-018 NONE: imm_out SHALL be 0.
REQ-019 Latency: exactly 1 cycle from instr_in sampled to imm_out/imm_sel/imm_valid/illegal updated.
REQ-020 Edge update, priority flush > stall > load.
REQ-021 flush=1: imm_out=0, imm_sel=0, imm_valid=0, illegal=0, regardless of stall or instr_valid.
REQ-022 stall=1, flush=0: all outputs hold previous values; instr_in ignored.
REQ-023 load, instr_valid=1: outputs take decoded values; imm_valid=1; illegal=1 iff class NONE.
REQ-024 load, instr_valid=0: bubble, identical to flush result.
REQ-025 Stall of any length followed by release SHALL resume with the instr_in present on the release edge; no instruction duplicated or lost beyond what the upstream register presents.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 reset=1 SHALL immediately (without clock) force imm_out=0, imm_sel=0, imm_valid=0, illegal=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; after deassertion first edge behaves per REQ-020.

Verification
REQ-029 LDUR 0xF85FF000, valid, no stall -> next edge imm_out=0xFFFFFFFFFFFFFFFF, imm_sel=1, imm_valid=1, illegal=0.
REQ-030 B 0x16000000 -> imm_out=0xFFFFFFFFF8000000, imm_sel=3; then CBZ 0xB4000020 -> imm_out=0x0000000000000004, imm_sel=4.
REQ-031 ADDI 0x913FFC00 -> imm_out=0x0000000000000FFF, imm_sel=2 (zero-extend, no sign fill).
REQ-032 Load ADDI 0x913FFC00, then 3 cycles stall=1 with instr_in=0xF85FF000 -> outputs hold 0xFFF/2; stall=1 and flush=1 same edge -> all outputs 0.
REQ-033 instr 0x00000000 valid -> illegal=1, imm_valid=1, imm_sel=0, imm_out=0; instr_valid=0 -> imm_valid=0, illegal=0.
REQ-034 Assert reset between clock edges while imm_valid=1 -> all outputs 0 before next edge; held 2 cycles with valid input -> outputs stay 0.

Source files
------------

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Decode stage immediate generator. Classifies the instruction word held in
//   the IF/ID register, extracts and extends its immediate field and registers
//   the result for EX. The stage register can be held by the hazard unit
//   (stall) or squashed to a bubble (flush). Flush overrides stall.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   instr_in     in  32   instruction word from IF/ID
//   instr_valid  in   1   instr_in is a real instruction (0 = bubble)
//   stall        in   1   hold the stage register
//   flush        in   1   load a bubble into the stage register
//   imm_out      out 64   extended (and, for branches, shifted) immediate
//   imm_sel      out  3   immediate class: 0 NONE, 1 DADDR9, 2 IMM12,
//                         3 BR26, 4 COND19, 5 SHAMT
//   imm_valid    out  1   held instruction is real
//   illegal      out  1   held instruction is valid but has no known opcode
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [63:0] imm_out,
  output logic [2:0]  imm_sel,
  output logic        imm_valid,
  output logic        illegal
);

  localparam logic [2:0] SEL_NONE   = 3'd0;
  localparam logic [2:0] SEL_DADDR9 = 3'd1;
  localparam logic [2:0] SEL_IMM12  = 3'd2;
  localparam logic [2:0] SEL_BR26   = 3'd3;
  localparam logic [2:0] SEL_COND19 = 3'd4;
  localparam logic [2:0] SEL_SHAMT  = 3'd5;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;

  logic [2:0]  sel_dec;
  logic [63:0] imm_dec;
  logic [63:0] cond_ext;
  logic [63:0] br_ext;

  logic [63:0] imm_q,     imm_d;
  logic [2:0]  sel_q,     sel_d;
  logic        valid_q,   valid_d;
  logic        illegal_q, illegal_d;

  assign op11 = instr_in[31:21];
  assign op10 = instr_in[31:22];
  assign op8  = instr_in[31:24];
  assign op6  = instr_in[31:26];

  // Branch offsets are word counts; sign-extend first, then scale to bytes.
  // Bits pushed past bit 63 by the shift are simply dropped.
  assign cond_ext = {{45{instr_in[23]}}, instr_in[23:5]} << BR_SHIFT;
  assign br_ext   = {{38{instr_in[25]}}, instr_in[25:0]} << BR_SHIFT;

  // Opcode classification; the if/else order is the match priority.
  always_comb begin
    sel_dec = SEL_NONE;
    if (op11 == 11'b11111000010 || op11 == 11'b11111000000) begin
      sel_dec = SEL_DADDR9;
    end else if (op11 == 11'b11010011011 || op11 == 11'b11010011010) begin
      sel_dec = SEL_SHAMT;
    end else if (op10 == 10'b1001000100 || op10 == 10'b1101000100) begin
      sel_dec = SEL_IMM12;
    end else if (op8 == 8'b10110100 || op8 == 8'b10110101 ||
                 op8 == 8'b01010100) begin
      sel_dec = SEL_COND19;
    end else if (op6 == 6'b000101 || op6 == 6'b100101) begin
      sel_dec = SEL_BR26;
    end
  end

  always_comb begin
    imm_dec = 64'd0;
    case (sel_dec)
      SEL_DADDR9: imm_dec = {{55{instr_in[20]}}, instr_in[20:12]};
      SEL_IMM12:  imm_dec = {52'd0, instr_in[21:10]};
      SEL_SHAMT:  imm_dec = {58'd0, instr_in[15:10]};
      SEL_COND19: imm_dec = cond_ext;
      SEL_BR26:   imm_dec = br_ext;
      default:    imm_dec = 64'd0;
    endcase
  end

  // Stage register next state: flush > stall > load. A load of an invalid
  // instruction produces the same bubble as a flush.
  always_comb begin
    imm_d     = imm_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush) begin
      imm_d     = 64'd0;
      sel_d     = SEL_NONE;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      if (instr_valid) begin
        imm_d     = imm_dec;
        sel_d     = sel_dec;
        valid_d   = 1'b1;
        illegal_d = (sel_dec == SEL_NONE);
      end else begin
        imm_d     = 64'd0;
        sel_d     = SEL_NONE;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q     <= 64'd0;
      sel_q     <= SEL_NONE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign imm_out   = imm_q;
  assign imm_sel   = sel_q;
  assign imm_valid = valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        stall;
  logic        flush;
  logic [63:0] imm_out;
  logic [2:0]  imm_sel;
  logic        imm_valid;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  imm_gen_stage #(.BR_SHIFT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .stall       (stall),
    .flush       (flush),
    .imm_out     (imm_out),
    .imm_sel     (imm_sel),
    .imm_valid   (imm_valid),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, clock once, sample 1 time unit later.
  task automatic drive(input logic [31:0] ins, input logic v,
                       input logic st, input logic fl);
    @(negedge clk);
    instr_in    = ins;
    instr_valid = v;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr_in = 32'hF85FF000; instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
      n_err++;
      $display("FAIL reset_state: got imm=%h sel=%0d v=%b ill=%b, want all 0",
               imm_out, imm_sel, imm_valid, illegal);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
    string       name;
  } vec_t;

  task automatic test_decode;
    vec_t v[$];
    v.push_back('{32'hF85FF000, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, "ldur_neg1"});
    v.push_back('{32'hF80FF000, 64'h00000000000000FF, 3'd1, 1'b0, "stur_pos"});
    v.push_back('{32'h16000000, 64'hFFFFFFFFF8000000, 3'd3, 1'b0, "b_minmax"});
    v.push_back('{32'hB4000020, 64'h0000000000000004, 3'd4, 1'b0, "cbz_one"});
    v.push_back('{32'h913FFC00, 64'h0000000000000FFF, 3'd2, 1'b0, "addi_fff"});
    v.push_back('{32'hD1200000, 64'h0000000000000800, 3'd2, 1'b0, "subi_800"});
    v.push_back('{32'hD3601400, 64'h0000000000000005, 3'd5, 1'b0, "lsl_5"});
    v.push_back('{32'hD340FC00, 64'h000000000000003F, 3'd5, 1'b0, "lsr_3f"});
    v.push_back('{32'hB5800000, 64'hFFFFFFFFFFF00000, 3'd4, 1'b0, "cbnz_neg"});
    v.push_back('{32'h54000060, 64'h000000000000000C, 3'd4, 1'b0, "bcond_3"});
    v.push_back('{32'h94000001, 64'h0000000000000004, 3'd3, 1'b0, "bl_one"});
    v.push_back('{32'h15FFFFFF, 64'h0000000007FFFFFC, 3'd3, 1'b0, "b_maxpos"});
    v.push_back('{32'hF8600000, 64'h0000000000000000, 3'd0, 1'b1, "near_ldur"});
    v.push_back('{32'h00000000, 64'h0000000000000000, 3'd0, 1'b1, "zero_word"});
    foreach (v[i]) begin
      drive(v[i].ins, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (imm_out !== v[i].imm || imm_sel !== v[i].sel ||
          imm_valid !== 1'b1 || illegal !== v[i].ill) begin
        n_err++;
        $display("FAIL decode_%s: got imm=%h sel=%0d v=%b ill=%b, want imm=%h sel=%0d v=1 ill=%b",
                 v[i].name, imm_out, imm_sel, imm_valid, illegal,
                 v[i].imm, v[i].sel, v[i].ill);
      end
    end
  endtask

  task automatic test_no_comb_path;
    drive(32'h913FFC00, 1'b1, 1'b0, 1'b0);
    #2;
    instr_in = 32'hF85FF000; flush = 1'b1;
    #1;
    n_cmp++;
    if (imm_out !== 64'hFFF || imm_sel !== 3'd2 || imm_valid !== 1'b1) begin
      n_err++;
      $display("FAIL no_comb_path: got imm=%h sel=%0d v=%b, want imm=fff sel=2 v=1",
               imm_out, imm_sel, imm_valid);
    end
    flush = 1'b0;
  endtask

  task automatic test_stall_flush;
    drive(32'h913FFC00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(32'hF85FF000, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (imm_out !== 64'hFFF || imm_sel !== 3'd2 || imm_valid !== 1'b1 || illegal !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got imm=%h sel=%0d v=%b ill=%b, want imm=fff sel=2 v=1 ill=0",
                 k, imm_out, imm_sel, imm_valid, illegal);
      end
    end
    drive(32'hF85FF000, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
      n_err++;
      $display("FAIL stall_and_flush: got imm=%h sel=%0d v=%b ill=%b, want all 0",
               imm_out, imm_sel, imm_valid, illegal);
    end
    // Stall, then release: the word present on the release edge is taken.
    drive(32'h913FFC00, 1'b1, 1'b0, 1'b0);
    drive(32'hB4000020, 1'b1, 1'b1, 1'b0);
    drive(32'hB4000020, 1'b1, 1'b1, 1'b0);
    drive(32'hF85FF000, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (imm_out !== 64'hFFFFFFFFFFFFFFFF || imm_sel !== 3'd1 || imm_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got imm=%h sel=%0d v=%b, want imm=ffffffffffffffff sel=1 v=1",
               imm_out, imm_sel, imm_valid);
    end
    drive(32'h16000000, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (imm_out !== 64'hFFFFFFFFF8000000 || imm_sel !== 3'd3) begin
      n_err++;
      $display("FAIL back_to_back: got imm=%h sel=%0d, want imm=fffffffff8000000 sel=3",
               imm_out, imm_sel);
    end
    drive(32'h16000000, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
      n_err++;
      $display("FAIL flush_only: got imm=%h sel=%0d v=%b ill=%b, want all 0",
               imm_out, imm_sel, imm_valid, illegal);
    end
  endtask

  task automatic test_bubble;
    drive(32'h00000000, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (illegal !== 1'b1 || imm_valid !== 1'b1 || imm_sel !== 3'd0 || imm_out !== 64'd0) begin
      n_err++;
      $display("FAIL illegal_valid: got imm=%h sel=%0d v=%b ill=%b, want imm=0 sel=0 v=1 ill=1",
               imm_out, imm_sel, imm_valid, illegal);
    end
    drive(32'hF85FF000, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
      n_err++;
      $display("FAIL bubble_load: got imm=%h sel=%0d v=%b ill=%b, want all 0",
               imm_out, imm_sel, imm_valid, illegal);
    end
  endtask

  task automatic test_async_reset;
    drive(32'hF85FF000, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
      n_err++;
      $display("FAIL async_reset: got imm=%h sel=%0d v=%b ill=%b, want all 0 before edge",
               imm_out, imm_sel, imm_valid, illegal);
    end
    for (int k = 0; k < 2; k++) begin
      drive(32'hF85FF000, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({imm_out, imm_sel, imm_valid, illegal} !== 69'd0) begin
        n_err++;
        $display("FAIL reset_held_%0d: got imm=%h sel=%0d v=%b ill=%b, want all 0",
                 k, imm_out, imm_sel, imm_valid, illegal);
      end
    end
    // Reset released while stall was asserted; first edge with stall low loads.
    drive(32'hB4000020, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'hB4000020, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (imm_out !== 64'h4 || imm_sel !== 3'd4 || imm_valid !== 1'b1 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_load: got imm=%h sel=%0d v=%b ill=%b, want imm=4 sel=4 v=1 ill=0",
               imm_out, imm_sel, imm_valid, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_no_comb_path();
    test_stall_flush();
    test_bubble();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
